// File: rtl/ad_ascii_fmt.sv
// ad_ascii_fmt: snapshots per-channel BCD voltages and sign bytes, then streams one ASCII
// frame over a valid/ready byte handshake. Define FMT_CHECKSUM_EN to append "*HH\r\n".
module ad_ascii_fmt #(
    parameter int unsigned NUM_CH = 8
) (
    input  logic        clk,
    input  logic        ad_reset,
    input  logic        start,
    input  logic [19:0] ch1_dec,
    input  logic [19:0] ch2_dec,
    input  logic [19:0] ch3_dec,
    input  logic [19:0] ch4_dec,
    input  logic [19:0] ch5_dec,
    input  logic [19:0] ch6_dec,
    input  logic [19:0] ch7_dec,
    input  logic [19:0] ch8_dec,
    input  logic [7:0]  ch1_sig,
    input  logic [7:0]  ch2_sig,
    input  logic [7:0]  ch3_sig,
    input  logic [7:0]  ch4_sig,
    input  logic [7:0]  ch5_sig,
    input  logic [7:0]  ch6_sig,
    input  logic [7:0]  ch7_sig,
    input  logic [7:0]  ch8_sig,
    input  logic        tx_ready,
    output logic [7:0]  tx_data,
    output logic        tx_valid,
    output logic        busy,
    output logic        frame_done
);

    localparam logic [2:0] LAST_CH   = 3'(NUM_CH - 1);
    localparam logic [3:0] LAST_BYTE = 4'd13;

`ifdef FMT_CHECKSUM_EN
    typedef enum logic [1:0] {StIdle, StSend, StCsum, StDone} state_t;
`else
    typedef enum logic [1:0] {StIdle, StSend, StDone} state_t;
`endif

    state_t      state_q, state_d;
    logic [3:0]  byte_q, byte_d;
    logic [2:0]  ch_q, ch_d;
    logic [7:0]  data_q, data_d;
    logic        valid_q, valid_d;
    logic        busy_q, busy_d;
    logic        done_q, done_d;
    logic        xfer;
`ifdef FMT_CHECKSUM_EN
    logic [7:0]  csum_q, csum_d;
    logic [2:0]  cidx_q, cidx_d;
`endif

    logic [19:0] dec_in     [8];
    logic [7:0]  sig_in     [8];
    logic [19:0] snap_dec_q [8];
    logic [7:0]  snap_sig_q [8];

    assign dec_in[0] = ch1_dec;
    assign dec_in[1] = ch2_dec;
    assign dec_in[2] = ch3_dec;
    assign dec_in[3] = ch4_dec;
    assign dec_in[4] = ch5_dec;
    assign dec_in[5] = ch6_dec;
    assign dec_in[6] = ch7_dec;
    assign dec_in[7] = ch8_dec;
    assign sig_in[0] = ch1_sig;
    assign sig_in[1] = ch2_sig;
    assign sig_in[2] = ch3_sig;
    assign sig_in[3] = ch4_sig;
    assign sig_in[4] = ch5_sig;
    assign sig_in[5] = ch6_sig;
    assign sig_in[6] = ch7_sig;
    assign sig_in[7] = ch8_sig;

    function automatic logic [7:0] digit_char(input logic [3:0] d);
        return (d > 4'd9) ? 8'h3F : {4'h3, d};
    endfunction

    function automatic logic [7:0] sign_char(input logic [7:0] s);
        return (s == 8'h2B || s == 8'h2D) ? s : 8'h20;
    endfunction

    // Byte idx of the line for channel ch (0-based); layout "CHn:Sd.ddddV\r\n".
    function automatic logic [7:0] line_byte(input logic [3:0]  idx,
                                             input logic [2:0]  ch,
                                             input logic [19:0] dec,
                                             input logic [7:0]  sig);
        logic [7:0] b;
        case (idx)
            4'd0:    b = 8'h43;
            4'd1:    b = 8'h48;
            4'd2:    b = 8'h31 + {5'd0, ch};
            4'd3:    b = 8'h3A;
            4'd4:    b = sign_char(sig);
            4'd5:    b = digit_char(dec[19:16]);
            4'd6:    b = 8'h2E;
            4'd7:    b = digit_char(dec[15:12]);
            4'd8:    b = digit_char(dec[11:8]);
            4'd9:    b = digit_char(dec[7:4]);
            4'd10:   b = digit_char(dec[3:0]);
            4'd11:   b = 8'h56;
            4'd12:   b = 8'h0D;
            4'd13:   b = 8'h0A;
            default: b = 8'h00;
        endcase
        return b;
    endfunction

`ifdef FMT_CHECKSUM_EN
    function automatic logic [7:0] hex_char(input logic [3:0] n);
        return (n > 4'd9) ? (8'h37 + {4'h0, n}) : {4'h3, n};
    endfunction

    function automatic logic [7:0] csum_byte(input logic [2:0] idx, input logic [7:0] x);
        logic [7:0] b;
        case (idx)
            3'd0:    b = 8'h2A;
            3'd1:    b = hex_char(x[7:4]);
            3'd2:    b = hex_char(x[3:0]);
            3'd3:    b = 8'h0D;
            3'd4:    b = 8'h0A;
            default: b = 8'h00;
        endcase
        return b;
    endfunction
`endif

    // Snapshot is plain data; it only matters once a frame has started.
    always_ff @(posedge clk) begin
        if (!ad_reset && state_q == StIdle && start) begin
            for (int i = 0; i < 8; i++) begin
                snap_dec_q[i] <= dec_in[i];
                snap_sig_q[i] <= sig_in[i];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (ad_reset) begin
            state_q <= StIdle;
            byte_q  <= 4'd0;
            ch_q    <= 3'd0;
            data_q  <= 8'h00;
            valid_q <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
`ifdef FMT_CHECKSUM_EN
            csum_q  <= 8'h00;
            cidx_q  <= 3'd0;
`endif
        end else begin
            state_q <= state_d;
            byte_q  <= byte_d;
            ch_q    <= ch_d;
            data_q  <= data_d;
            valid_q <= valid_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
`ifdef FMT_CHECKSUM_EN
            csum_q  <= csum_d;
            cidx_q  <= cidx_d;
`endif
        end
    end

    assign xfer = valid_q & tx_ready;

    always_comb begin
        state_d = state_q;
        byte_d  = byte_q;
        ch_d    = ch_q;
        data_d  = data_q;
        valid_d = valid_q;
        busy_d  = busy_q;
        done_d  = 1'b0;
`ifdef FMT_CHECKSUM_EN
        csum_d  = csum_q;
        cidx_d  = cidx_q;
`endif
        case (state_q)
            StIdle: begin
                if (start) begin
                    state_d = StSend;
                    byte_d  = 4'd0;
                    ch_d    = 3'd0;
                    data_d  = 8'h43;
                    valid_d = 1'b1;
                    busy_d  = 1'b1;
`ifdef FMT_CHECKSUM_EN
                    csum_d  = 8'h00;
`endif
                end
            end
            StSend: begin
                if (xfer) begin
`ifdef FMT_CHECKSUM_EN
                    csum_d = csum_q ^ data_q;
`endif
                    if (byte_q == LAST_BYTE) begin
                        byte_d = 4'd0;
                        if (ch_q == LAST_CH) begin
`ifdef FMT_CHECKSUM_EN
                            state_d = StCsum;
                            cidx_d  = 3'd0;
                            data_d  = csum_byte(3'd0, 8'h00);
`else
                            state_d = StDone;
                            valid_d = 1'b0;
                            busy_d  = 1'b0;
                            done_d  = 1'b1;
`endif
                        end else begin
                            ch_d   = ch_q + 3'd1;
                            data_d = 8'h43;
                        end
                    end else begin
                        byte_d = byte_q + 4'd1;
                        data_d = line_byte(byte_q + 4'd1, ch_q, snap_dec_q[ch_q],
                                           snap_sig_q[ch_q]);
                    end
                end
            end
`ifdef FMT_CHECKSUM_EN
            StCsum: begin
                // csum_q already holds the XOR of the whole body by the time '*' is shown.
                if (xfer) begin
                    if (cidx_q == 3'd4) begin
                        state_d = StDone;
                        valid_d = 1'b0;
                        busy_d  = 1'b0;
                        done_d  = 1'b1;
                    end else begin
                        cidx_d = cidx_q + 3'd1;
                        data_d = csum_byte(cidx_q + 3'd1, csum_q);
                    end
                end
            end
`endif
            StDone: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    assign tx_data    = data_q;
    assign tx_valid   = valid_q;
    assign busy       = busy_q;
    assign frame_done = done_q;

endmodule

// File: tb/tb_ad_ascii_fmt.sv
// Bench for ad_ascii_fmt: a 1-channel and an 8-channel instance share stimulus; each
// frame is compared against a text model built from the line format rules.
`timescale 1ns/1ps
module tb_ad_ascii_fmt;

    logic        clk = 1'b0;
    logic        ad_reset;
    logic        start;
    logic        tx_ready;
    logic [19:0] dec [8];
    logic [7:0]  sig [8];

    logic [7:0]  d1_data, d8_data;
    logic        d1_valid, d8_valid, d1_busy, d8_busy, d1_done, d8_done;

    int total = 0;
    int bad   = 0;

    logic [7:0] got_q [$];
    logic [7:0] exp_q [$];
    int first_valid, done_cyc, done_cnt, stall_viol, busy_lows;
    logic done_busy, post_rst_valid, post_rst_busy;

    always #10 clk = ~clk;

    ad_ascii_fmt #(.NUM_CH(1)) u_dut1 (
        .clk(clk), .ad_reset(ad_reset), .start(start),
        .ch1_dec(dec[0]), .ch2_dec(dec[1]), .ch3_dec(dec[2]), .ch4_dec(dec[3]),
        .ch5_dec(dec[4]), .ch6_dec(dec[5]), .ch7_dec(dec[6]), .ch8_dec(dec[7]),
        .ch1_sig(sig[0]), .ch2_sig(sig[1]), .ch3_sig(sig[2]), .ch4_sig(sig[3]),
        .ch5_sig(sig[4]), .ch6_sig(sig[5]), .ch7_sig(sig[6]), .ch8_sig(sig[7]),
        .tx_ready(tx_ready), .tx_data(d1_data), .tx_valid(d1_valid), .busy(d1_busy),
        .frame_done(d1_done)
    );

    ad_ascii_fmt #(.NUM_CH(8)) u_dut8 (
        .clk(clk), .ad_reset(ad_reset), .start(start),
        .ch1_dec(dec[0]), .ch2_dec(dec[1]), .ch3_dec(dec[2]), .ch4_dec(dec[3]),
        .ch5_dec(dec[4]), .ch6_dec(dec[5]), .ch7_dec(dec[6]), .ch8_dec(dec[7]),
        .ch1_sig(sig[0]), .ch2_sig(sig[1]), .ch3_sig(sig[2]), .ch4_sig(sig[3]),
        .ch5_sig(sig[4]), .ch6_sig(sig[5]), .ch7_sig(sig[6]), .ch8_sig(sig[7]),
        .tx_ready(tx_ready), .tx_data(d8_data), .tx_valid(d8_valid), .busy(d8_busy),
        .frame_done(d8_done)
    );

    function automatic logic [7:0] dchar(input logic [3:0] d);
        string s;
        if (d > 9) return 8'h3F;
        s = $sformatf("%0d", d);
        return s[0];
    endfunction

    task automatic push_str(input string s);
        for (int i = 0; i < s.len(); i++) exp_q.push_back(s[i]);
    endtask

    // Reference frame for n channels from the current dec/sig values.
    task automatic build_expected(input int n);
        string s;
        logic [7:0] x;
        exp_q.delete();
        for (int c = 0; c < n; c++) begin
            push_str($sformatf("CH%0d:", c + 1));
            exp_q.push_back((sig[c] == "+" || sig[c] == "-") ? sig[c] : " ");
            exp_q.push_back(dchar(dec[c][19:16]));
            exp_q.push_back(".");
            exp_q.push_back(dchar(dec[c][15:12]));
            exp_q.push_back(dchar(dec[c][11:8]));
            exp_q.push_back(dchar(dec[c][7:4]));
            exp_q.push_back(dchar(dec[c][3:0]));
            exp_q.push_back("V");
            exp_q.push_back(8'h0D);
            exp_q.push_back(8'h0A);
        end
`ifdef FMT_CHECKSUM_EN
        x = 8'h00;
        foreach (exp_q[i]) x ^= exp_q[i];
        s = $sformatf("*%02X", x);
        push_str(s);
        exp_q.push_back(8'h0D);
        exp_q.push_back(8'h0A);
`endif
    endtask

    task automatic randomize_inputs(input bit valid_bcd);
        logic [7:0] pick;
        for (int c = 0; c < 8; c++) begin
            if (valid_bcd)
                dec[c] = {4'($urandom_range(0, 9)), 4'($urandom_range(0, 9)),
                          4'($urandom_range(0, 9)), 4'($urandom_range(0, 9)),
                          4'($urandom_range(0, 9))};
            else
                dec[c] = 20'($urandom);
            pick = 8'($urandom);
            sig[c] = (pick[1:0] == 2'd0) ? 8'h2B : (pick[1:0] == 2'd1) ? 8'h2D : 8'($urandom);
        end
    endtask

    task automatic do_reset();
        ad_reset = 1'b1;
        start    = 1'b0;
        tx_ready = 1'b0;
        repeat (2) @(negedge clk);
        ad_reset = 1'b0;
        @(negedge clk);
    endtask

    task automatic start_frame();
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    // Observes one DUT from the cycle after start. mode: 0 ready=1, 1 toggle, 2 random.
    // poke_at: cycle to set ch1_dec=99999 (start re-pulsed 5 cycles later); rst_at: reset cycle.
    task automatic capture(input int which, input int mode, input int poke_at,
                           input int rst_at, input int max_cyc);
        logic v, bz, dn, r, prev_stall;
        logic [7:0] d, prev_d;
        got_q.delete();
        first_valid = -1; done_cyc = -1; done_cnt = 0; stall_viol = 0; busy_lows = 0;
        done_busy = 1'b1; post_rst_valid = 1'b1; post_rst_busy = 1'b1;
        prev_stall = 1'b0; prev_d = 8'h00;
        for (int i = 0; i < max_cyc; i++) begin
            v  = (which == 1) ? d1_valid : d8_valid;
            d  = (which == 1) ? d1_data  : d8_data;
            bz = (which == 1) ? d1_busy  : d8_busy;
            dn = (which == 1) ? d1_done  : d8_done;
            if (rst_at >= 0 && i == rst_at + 1) begin
                post_rst_valid = v;
                post_rst_busy  = bz;
            end
            if (v && first_valid < 0) first_valid = i;
            if (prev_stall && (!v || d !== prev_d)) stall_viol++;
            if (dn) begin
                done_cnt++;
                if (done_cyc < 0) begin
                    done_cyc  = i;
                    done_busy = bz;
                end
            end
            if (done_cyc < 0 && !bz && (rst_at < 0 || i <= rst_at)) busy_lows++;
            case (mode)
                0:       r = 1'b1;
                1:       r = (i % 2 == 0);
                default: r = 1'($urandom_range(0, 1));
            endcase
            tx_ready = r;
            if (v && r && i != rst_at) got_q.push_back(d);
            prev_stall = v && !r;
            prev_d     = d;
            if (poke_at >= 0 && i == poke_at) dec[0] = 20'h99999;
            start    = (poke_at >= 0 && i == poke_at + 5);
            ad_reset = (i == rst_at);
            @(negedge clk);
            if ((done_cyc >= 0 && i >= done_cyc + 4) || (rst_at >= 0 && i >= rst_at + 20)) break;
        end
        start    = 1'b0;
        ad_reset = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        total += 8;
        if (d1_data !== 8'h00) begin bad++; $display("FAIL reset_d1_data got=%h want=00", d1_data); end
        if (d1_valid !== 1'b0) begin bad++; $display("FAIL reset_d1_valid got=%b want=0", d1_valid); end
        if (d1_busy !== 1'b0)  begin bad++; $display("FAIL reset_d1_busy got=%b want=0", d1_busy); end
        if (d1_done !== 1'b0)  begin bad++; $display("FAIL reset_d1_done got=%b want=0", d1_done); end
        if (d8_data !== 8'h00) begin bad++; $display("FAIL reset_d8_data got=%h want=00", d8_data); end
        if (d8_valid !== 1'b0) begin bad++; $display("FAIL reset_d8_valid got=%b want=0", d8_valid); end
        if (d8_busy !== 1'b0)  begin bad++; $display("FAIL reset_d8_busy got=%b want=0", d8_busy); end
        if (d8_done !== 1'b0)  begin bad++; $display("FAIL reset_d8_done got=%b want=0", d8_done); end
    endtask

    task automatic test_single_channel();
        do_reset();
        randomize_inputs(1'b1);
        dec[0] = 20'h12345;
        sig[0] = 8'h2B;
        build_expected(1);
        start_frame();
        capture(1, 0, -1, -1, 100);
        total++;
        if (got_q.size() != exp_q.size()) begin
            bad++; $display("FAIL single_len got=%0d want=%0d", got_q.size(), exp_q.size());
        end
        for (int i = 0; i < got_q.size() && i < exp_q.size(); i++) begin
            total++;
            if (got_q[i] !== exp_q[i]) begin
                bad++; $display("FAIL single_byte[%0d] got=%h want=%h", i, got_q[i], exp_q[i]);
            end
        end
        total += 5;
        if (first_valid != 0) begin bad++; $display("FAIL single_first got=%0d want=0", first_valid); end
        if (done_cyc != exp_q.size()) begin
            bad++; $display("FAIL single_done_cycle got=%0d want=%0d", done_cyc, exp_q.size());
        end
        if (done_cnt != 1) begin bad++; $display("FAIL single_done_count got=%0d want=1", done_cnt); end
        if (busy_lows != 0) begin bad++; $display("FAIL single_busy_gap got=%0d want=0", busy_lows); end
        if (done_busy !== 1'b0) begin bad++; $display("FAIL single_busy_at_done got=%b want=0", done_busy); end
    endtask

    task automatic test_toggle_ready();
        do_reset();
        for (int c = 0; c < 8; c++) begin
            dec[c] = 20'h05000;
            sig[c] = 8'h2D;
        end
        build_expected(8);
        start_frame();
        capture(8, 1, -1, -1, 600);
        total++;
        if (got_q.size() != exp_q.size()) begin
            bad++; $display("FAIL toggle_len got=%0d want=%0d", got_q.size(), exp_q.size());
        end
        for (int i = 0; i < got_q.size() && i < exp_q.size(); i++) begin
            total++;
            if (got_q[i] !== exp_q[i]) begin
                bad++; $display("FAIL toggle_byte[%0d] got=%h want=%h", i, got_q[i], exp_q[i]);
            end
        end
        total += 2;
        if (stall_viol != 0) begin bad++; $display("FAIL toggle_hold got=%0d want=0", stall_viol); end
        if (done_cnt != 1) begin bad++; $display("FAIL toggle_done_count got=%0d want=1", done_cnt); end
    endtask

    task automatic test_invalid_bcd();
        string lit;
        do_reset();
        dec[0] = 20'h1A0F3;
        sig[0] = 8'h00;
        lit = "CH1: 1.?0?3V";
        start_frame();
        capture(1, 0, -1, -1, 100);
        for (int i = 0; i < 14; i++) begin
            total++;
            if (i >= got_q.size()) begin
                bad++; $display("FAIL bcd_byte[%0d] got=missing want=present", i);
            end else if (got_q[i] !== ((i < 12) ? lit[i] : ((i == 12) ? 8'h0D : 8'h0A))) begin
                bad++; $display("FAIL bcd_byte[%0d] got=%h want=%h", i, got_q[i],
                                (i < 12) ? lit[i] : ((i == 12) ? 8'h0D : 8'h0A));
            end
        end
    endtask

    task automatic test_snapshot_and_busy_start();
        do_reset();
        dec[0] = 20'h00001;
        sig[0] = 8'h2B;
        build_expected(1);
        start_frame();
        capture(1, 0, 0, -1, 100);
        total += 2;
        if (got_q.size() != exp_q.size()) begin
            bad++; $display("FAIL snap_len got=%0d want=%0d", got_q.size(), exp_q.size());
        end
        if (done_cnt != 1) begin bad++; $display("FAIL snap_done_count got=%0d want=1", done_cnt); end
        for (int i = 0; i < got_q.size() && i < exp_q.size(); i++) begin
            total++;
            if (got_q[i] !== exp_q[i]) begin
                bad++; $display("FAIL snap_byte[%0d] got=%h want=%h", i, got_q[i], exp_q[i]);
            end
        end
    endtask

    task automatic test_reset_mid_frame();
        do_reset();
        randomize_inputs(1'b1);
        start_frame();
        capture(8, 0, -1, 20, 400);
        total += 4;
        if (post_rst_valid !== 1'b0) begin bad++; $display("FAIL midrst_valid got=%b want=0", post_rst_valid); end
        if (post_rst_busy !== 1'b0)  begin bad++; $display("FAIL midrst_busy got=%b want=0", post_rst_busy); end
        if (done_cnt != 0) begin bad++; $display("FAIL midrst_done got=%0d want=0", done_cnt); end
        if (got_q.size() != 20) begin bad++; $display("FAIL midrst_bytes got=%0d want=20", got_q.size()); end
        randomize_inputs(1'b1);
        build_expected(8);
        start_frame();
        capture(8, 2, -1, -1, 1000);
        total += 2;
        if (got_q.size() != exp_q.size()) begin
            bad++; $display("FAIL fresh_len got=%0d want=%0d", got_q.size(), exp_q.size());
        end
        if (done_cnt != 1) begin bad++; $display("FAIL fresh_done_count got=%0d want=1", done_cnt); end
        for (int i = 0; i < got_q.size() && i < exp_q.size(); i++) begin
            total++;
            if (got_q[i] !== exp_q[i]) begin
                bad++; $display("FAIL fresh_byte[%0d] got=%h want=%h", i, got_q[i], exp_q[i]);
            end
        end
    endtask

    task automatic test_random_frames();
        int which;
        for (int k = 0; k < 6; k++) begin
            which = (k % 2 == 0) ? 8 : 1;
            do_reset();
            randomize_inputs(k % 3 != 0);
            build_expected(which);
            start_frame();
            capture(which, 2, -1, -1, 1000);
            total += 3;
            if (got_q.size() != exp_q.size()) begin
                bad++; $display("FAIL rand%0d_len got=%0d want=%0d", k, got_q.size(), exp_q.size());
            end
            if (stall_viol != 0) begin bad++; $display("FAIL rand%0d_hold got=%0d want=0", k, stall_viol); end
            if (done_cnt != 1) begin bad++; $display("FAIL rand%0d_done got=%0d want=1", k, done_cnt); end
            for (int i = 0; i < got_q.size() && i < exp_q.size(); i++) begin
                total++;
                if (got_q[i] !== exp_q[i]) begin
                    bad++; $display("FAIL rand%0d_byte[%0d] got=%h want=%h", k, i, got_q[i], exp_q[i]);
                end
            end
        end
    endtask

    initial begin
        ad_reset = 1'b1;
        start    = 1'b0;
        tx_ready = 1'b0;
        for (int c = 0; c < 8; c++) begin
            dec[c] = 20'h0;
            sig[c] = 8'h0;
        end
        @(negedge clk);
        test_reset();
        test_single_channel();
        test_toggle_ready();
        test_invalid_bcd();
        test_snapshot_and_busy_start();
        test_reset_mid_frame();
        test_random_frames();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #2ms;
        $display("FAIL watchdog got=timeout want=finish");
        $fatal(1, "watchdog expired");
    end

endmodule
